// File: rtl/structure1_fc1fc2_bufctrl.sv
// Ping-pong buffer controller between fc1 (port A writer) and fc2 (port B indexed reader).
// Two BRAM banks alternate ownership; full flags gate fc1 backpressure and fc2 readability.
module structure1_fc1fc2_bufctrl #(
  parameter int FRAME_LEN  = 120,
  parameter int BANK1_BASE = 8192,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fc1_valid,
  input  logic signed [DATA_W-1:0] fc1_data,
  output logic                     fc1_ready,
  output logic                     fc2_frame_ready,
  input  logic                     fc2_req,
  input  logic [ADDR_W-2:0]        fc2_idx,
  output logic                     fc2_rvalid,
  output logic signed [DATA_W-1:0] fc2_rdata,
  input  logic                     fc2_done,
  output logic                     err,
  output logic [7:0]               frames_done,
  output logic                     bram_wea,
  output logic [ADDR_W-1:0]        bram_addra,
  output logic signed [DATA_W-1:0] bram_dina,
  output logic                     bram_enb,
  output logic [ADDR_W-1:0]        bram_addrb,
  input  logic signed [DATA_W-1:0] bram_doutb
);

  localparam logic [ADDR_W-1:0] BASE1     = ADDR_W'(BANK1_BASE);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] FRAME_LIM = ADDR_W'(FRAME_LEN);

  function automatic logic [ADDR_W-1:0] bank_base(input logic bank);
    return bank ? BASE1 : '0;
  endfunction

  logic [1:0]               full_q, full_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0]        wcnt_q, wcnt_d;
  logic                     err_q, err_d;
  logic [7:0]               frames_done_q, frames_done_d;

  logic                     set_pend_p1, set_pend_d;
  logic                     set_bank_p1, set_bank_d;
  logic                     wea_p1, wea_d;
  logic [ADDR_W-1:0]        addra_p1, addra_d;
  logic signed [DATA_W-1:0] dina_p1, dina_d;
  logic                     vld_p1, vld_d;

  logic                     accept;
  logic                     last_elem;
  logic                     idx_ok;
  logic                     rd_ok;
  logic                     rd_bad;
  logic                     rel_ok;
  logic                     done_bad;

  // Stage p0: handshake decode and port B address, all combinational
  always_comb begin
    fc2_frame_ready = full_q[rd_bank_q];
    fc1_ready       = !rst && !full_q[wr_bank_q];
    accept          = fc1_valid && fc1_ready;
    last_elem       = (wcnt_q == LAST_IDX);
    idx_ok          = ({1'b0, fc2_idx} < FRAME_LIM);
    rd_ok           = fc2_req && fc2_frame_ready && idx_ok;
    rd_bad          = fc2_req && !rd_ok;
    rel_ok          = fc2_done && fc2_frame_ready;
    done_bad        = fc2_done && !fc2_frame_ready;
    bram_enb        = !rst && rd_ok;
    bram_addrb      = bram_enb ? (bank_base(rd_bank_q) + {1'b0, fc2_idx}) : '0;
  end

  always_comb begin
    full_d        = full_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wcnt_d        = wcnt_q;
    err_d         = err_q | rd_bad | done_bad;
    frames_done_d = frames_done_q;
    set_pend_d    = 1'b0;
    set_bank_d    = wr_bank_q;
    wea_d         = accept;
    addra_d       = addra_p1;
    dina_d        = dina_p1;
    vld_d         = bram_enb;

    // A bank is marked full on the edge its final BRAM write lands.
    if (set_pend_p1) begin
      full_d[set_bank_p1] = 1'b1;
    end
    if (rel_ok) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      frames_done_d     = frames_done_q + 8'd1;
    end

    if (accept) begin
      addra_d = bank_base(wr_bank_q) + wcnt_q;
      dina_d  = fc1_data;
      if (last_elem) begin
        wcnt_d     = '0;
        wr_bank_d  = ~wr_bank_q;
        set_pend_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  // Stage p1: registered state, port A write stage and read-valid
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wcnt_q        <= '0;
      err_q         <= 1'b0;
      frames_done_q <= '0;
      set_pend_p1   <= 1'b0;
      set_bank_p1   <= 1'b0;
      wea_p1        <= 1'b0;
      addra_p1      <= '0;
      dina_p1       <= '0;
      vld_p1        <= 1'b0;
    end else begin
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wcnt_q        <= wcnt_d;
      err_q         <= err_d;
      frames_done_q <= frames_done_d;
      set_pend_p1   <= set_pend_d;
      set_bank_p1   <= set_bank_d;
      wea_p1        <= wea_d;
      addra_p1      <= addra_d;
      dina_p1       <= dina_d;
      vld_p1        <= vld_d;
    end
  end

  // Output stage: registered write port, BRAM data passed through while valid
  always_comb begin
    bram_wea    = wea_p1;
    bram_addra  = addra_p1;
    bram_dina   = dina_p1;
    fc2_rvalid  = vld_p1;
    fc2_rdata   = vld_p1 ? bram_doutb : '0;
    err         = err_q;
    frames_done = frames_done_q;
  end

endmodule

// File: tb/tb_structure1_fc1fc2_bufctrl.sv
// Directed bench for the fc1/fc2 ping-pong controller with a behavioural dual-port BRAM.
module tb_structure1_fc1fc2_bufctrl;

  localparam int FRAME_LEN  = 4;
  localparam int BANK1_BASE = 16;
  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 18;

  logic              clk;
  logic              rst;
  logic              fc1_valid;
  logic [DATA_W-1:0] fc1_data;
  logic              fc1_ready;
  logic              fc2_frame_ready;
  logic              fc2_req;
  logic [ADDR_W-2:0] fc2_idx;
  logic              fc2_rvalid;
  logic [DATA_W-1:0] fc2_rdata;
  logic              fc2_done;
  logic              err;
  logic [7:0]        frames_done;
  logic              bram_wea;
  logic [ADDR_W-1:0] bram_addra;
  logic [DATA_W-1:0] bram_dina;
  logic              bram_enb;
  logic [ADDR_W-1:0] bram_addrb;
  logic [DATA_W-1:0] bram_doutb;

  int n_chk;
  int n_pass;

  structure1_fc1fc2_bufctrl #(
    .FRAME_LEN (FRAME_LEN),
    .BANK1_BASE(BANK1_BASE),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fc1_valid      (fc1_valid),
    .fc1_data       (fc1_data),
    .fc1_ready      (fc1_ready),
    .fc2_frame_ready(fc2_frame_ready),
    .fc2_req        (fc2_req),
    .fc2_idx        (fc2_idx),
    .fc2_rvalid     (fc2_rvalid),
    .fc2_rdata      (fc2_rdata),
    .fc2_done       (fc2_done),
    .err            (err),
    .frames_done    (frames_done),
    .bram_wea       (bram_wea),
    .bram_addra     (bram_addra),
    .bram_dina      (bram_dina),
    .bram_enb       (bram_enb),
    .bram_addrb     (bram_addrb),
    .bram_doutb     (bram_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM, one-cycle read latency on port B
  logic [DATA_W-1:0] mem [0:31];
  initial bram_doutb = '0;
  always @(posedge clk) begin
    if (bram_wea) mem[bram_addra[4:0]] <= bram_dina;
    if (bram_enb) bram_doutb <= mem[bram_addrb[4:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    fc1_valid = 1'b0;
    fc2_req   = 1'b0;
    fc2_done  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic write_frame(input int d0, input int a0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      fc1_valid = 1'b1;
      fc1_data  = DATA_W'(d0 + i);
      #1;
      check_eq("wr_ready", 32'(fc1_ready), 1);
      tick();
      check_eq("wr_wea", 32'(bram_wea), 1);
      check_eq("wr_addra", 32'(bram_addra), a0 + i);
      check_eq("wr_dina", 32'(bram_dina), d0 + i);
    end
    fc1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b1;
    fc1_valid = 1'b1;
    fc1_data  = 18'h3;
    fc2_req   = 1'b1;
    fc2_idx   = '0;
    fc2_done  = 1'b0;
    tick();
    tick();
    check_eq("rst_fc1_ready", 32'(fc1_ready), 0);
    check_eq("rst_wea", 32'(bram_wea), 0);
    check_eq("rst_addra", 32'(bram_addra), 0);
    check_eq("rst_dina", 32'(bram_dina), 0);
    check_eq("rst_enb", 32'(bram_enb), 0);
    check_eq("rst_addrb", 32'(bram_addrb), 0);
    check_eq("rst_rvalid", 32'(fc2_rvalid), 0);
    check_eq("rst_rdata", 32'(fc2_rdata), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_frames", 32'(frames_done), 0);
    check_eq("rst_frame_ready", 32'(fc2_frame_ready), 0);
    fc1_valid = 1'b0;
    fc2_req   = 1'b0;
    rst       = 1'b0;
    #1;

    // First frame into bank 0
    write_frame(32'hA, 0);
    check_eq("fr_ready_t1", 32'(fc2_frame_ready), 0);
    tick();
    check_eq("fr_ready_t2", 32'(fc2_frame_ready), 1);

    // Single read then back-to-back reads
    fc2_req = 1'b1;
    fc2_idx = 13'd2;
    #1;
    check_eq("rd_enb", 32'(bram_enb), 1);
    check_eq("rd_addrb", 32'(bram_addrb), 2);
    check_eq("rd_rvalid_t0", 32'(fc2_rvalid), 0);
    tick();
    fc2_idx = 13'd0;
    #1;
    check_eq("rd_rvalid", 32'(fc2_rvalid), 1);
    check_eq("rd_rdata", 32'(fc2_rdata), 32'hC);
    tick();
    fc2_idx = 13'd3;
    #1;
    check_eq("b2b_rdata0", 32'(fc2_rdata), 32'hA);
    tick();
    fc2_req = 1'b0;
    #1;
    check_eq("b2b_rdata3", 32'(fc2_rdata), 32'hD);
    check_eq("b2b_err", 32'(err), 0);
    tick();

    // Second frame into bank 1, then backpressure
    write_frame(32'h10, BANK1_BASE);
    check_eq("pp_stall_ready", 32'(fc1_ready), 0);
    fc1_valid = 1'b1;
    fc1_data  = 18'h99;
    tick();
    check_eq("pp_full", 32'(dut.full_q), 32'h3);
    check_eq("pp_no_wr", 32'(bram_wea), 0);
    tick();
    check_eq("pp_no_wr2", 32'(bram_wea), 0);
    check_eq("pp_stall_err", 32'(err), 0);
    fc1_valid = 1'b0;
    fc2_done  = 1'b1;
    tick();
    fc2_done = 1'b0;
    #1;
    check_eq("pp_rel_ready", 32'(fc1_ready), 1);
    check_eq("pp_rd_bank", 32'(dut.rd_bank_q), 1);
    check_eq("pp_frames", 32'(frames_done), 1);
    check_eq("pp_frame_ready", 32'(fc2_frame_ready), 1);
    fc2_req = 1'b1;
    fc2_idx = 13'd1;
    #1;
    check_eq("pp_addrb", 32'(bram_addrb), BANK1_BASE + 1);
    tick();
    fc2_req = 1'b0;
    #1;
    check_eq("pp_rdata", 32'(fc2_rdata), 32'h11);

    // Read before any frame
    do_reset();
    fc2_req = 1'b1;
    fc2_idx = 13'd0;
    #1;
    check_eq("err1_enb", 32'(bram_enb), 0);
    tick();
    fc2_req = 1'b0;
    #1;
    check_eq("err1_err", 32'(err), 1);
    check_eq("err1_rvalid", 32'(fc2_rvalid), 0);

    // Out-of-range index on a ready frame
    do_reset();
    check_eq("err2_cleared", 32'(err), 0);
    write_frame(32'hA, 0);
    tick();
    fc2_req = 1'b1;
    fc2_idx = 13'd4;
    #1;
    check_eq("err2_enb", 32'(bram_enb), 0);
    tick();
    fc2_req = 1'b0;
    #1;
    check_eq("err2_err", 32'(err), 1);
    check_eq("err2_rvalid", 32'(fc2_rvalid), 0);

    // Release with no ready frame
    do_reset();
    fc2_done = 1'b1;
    tick();
    fc2_done = 1'b0;
    #1;
    check_eq("err3_err", 32'(err), 1);
    check_eq("err3_frames", 32'(frames_done), 0);

    // Release coinciding with bank 1 becoming full, read in the same cycle
    do_reset();
    write_frame(32'h30, 0);
    tick();
    write_frame(32'h40, BANK1_BASE);
    fc2_req  = 1'b1;
    fc2_idx  = 13'd1;
    fc2_done = 1'b1;
    #1;
    check_eq("sim_enb", 32'(bram_enb), 1);
    check_eq("sim_addrb", 32'(bram_addrb), 1);
    tick();
    fc2_req  = 1'b0;
    fc2_done = 1'b0;
    #1;
    check_eq("sim_rd_bank", 32'(dut.rd_bank_q), 1);
    check_eq("sim_frame_ready", 32'(fc2_frame_ready), 1);
    check_eq("sim_full", 32'(dut.full_q), 32'h2);
    check_eq("sim_rvalid", 32'(fc2_rvalid), 1);
    check_eq("sim_rdata", 32'(fc2_rdata), 32'h31);
    check_eq("sim_frames", 32'(frames_done), 1);
    check_eq("sim_fc1_ready", 32'(fc1_ready), 1);

    // Partial frame discarded by reset
    do_reset();
    for (int i = 0; i < 2; i++) begin
      fc1_valid = 1'b1;
      fc1_data  = DATA_W'(32'h50 + i);
      tick();
    end
    fc1_valid = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("mid_frames", 32'(frames_done), 0);
    check_eq("mid_err", 32'(err), 0);
    check_eq("mid_full", 32'(dut.full_q), 0);
    check_eq("mid_frame_ready", 32'(fc2_frame_ready), 0);
    write_frame(32'h60, 0);
    tick();
    check_eq("mid_ready", 32'(fc2_frame_ready), 1);
    fc2_req = 1'b1;
    fc2_idx = 13'd1;
    tick();
    fc2_req = 1'b0;
    #1;
    check_eq("mid_rdata", 32'(fc2_rdata), 32'h61);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
